// File: rtl/peripheral_mpram_wb_nport.sv
`default_nettype none
// ============================================================================
// Module : peripheral_mpram_wb_nport
// Brief  : N-port Wishbone RAM; ports share one memory via a round-robin arbiter
//          with lockable incrementing/constant bursts.
// Rev    : 1.0  initial release
// ============================================================================

module peripheral_mpram_wb_nport #(
  parameter int DEPTH   = 256,
  parameter     MEMFILE = "",
  parameter int DW      = 32,
  parameter int PORTS   = 2,
  parameter int AW      = $clog2(DEPTH) + $clog2(DW / 8)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [PORTS*AW-1:0]     wb_adr_i,
  input  logic [PORTS*DW-1:0]     wb_dat_i,
  input  logic [PORTS*DW/8-1:0]   wb_sel_i,
  input  logic [PORTS-1:0]        wb_we_i,
  input  logic [PORTS-1:0]        wb_cyc_i,
  input  logic [PORTS-1:0]        wb_stb_i,
  input  logic [PORTS*3-1:0]      wb_cti_i,
  input  logic [PORTS*2-1:0]      wb_bte_i,
  output logic [PORTS-1:0]        wb_ack_o,
  output logic [PORTS-1:0]        wb_err_o,
  output logic [PORTS*DW-1:0]     wb_dat_o
);

  localparam int c_bw  = DW / 8;
  localparam int c_bsh = $clog2(c_bw);
  localparam int c_wiw = AW - c_bsh;
  localparam int c_pw  = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [c_wiw:0]   c_depth     = (c_wiw + 1)'(DEPTH);
  localparam logic [c_wiw-1:0] c_one       = c_wiw'(1);
  localparam logic [c_wiw-1:0] c_m4        = c_wiw'(3);
  localparam logic [c_wiw-1:0] c_m8        = c_wiw'(7);
  localparam logic [c_wiw-1:0] c_m16       = c_wiw'(15);
  localparam logic [2:0]       c_cti_const = 3'b001;
  localparam logic [2:0]       c_cti_incr  = 3'b010;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DW-1:0]    r_dat [PORTS];
  logic [PORTS-1:0] r_ack;
  logic [PORTS-1:0] r_err;
  logic             r_lock;
  logic [c_pw-1:0]  r_lock_port;
  logic [c_pw-1:0]  r_ptr;
  logic [c_wiw-1:0] r_cnt;

  logic [c_wiw-1:0] w_widx [PORTS];
  logic [2:0]       w_cti  [PORTS];
  logic [1:0]       w_bte  [PORTS];
  logic [PORTS-1:0] w_burst;
  logic [PORTS-1:0] w_req;
  logic             w_lock_live;
  logic             w_gnt_vld;
  logic [c_pw-1:0]  w_gnt;
  logic [c_pw-1:0]  w_ptr_nxt;
  logic [2:0]       w_cti_g;
  logic [1:0]       w_bte_g;
  logic             w_we_g;
  logic [c_bw-1:0]  w_sel_g;
  logic [DW-1:0]    w_wdat_g;
  logic             w_burst_g;
  logic [c_wiw-1:0] w_addr;
  logic [c_wiw-1:0] w_cnt_nxt;
  logic             w_bad;

  function automatic logic [c_pw-1:0] f_rr(input logic [c_pw-1:0] base, input int ofs);
    int s;
    s = (int'(base) + ofs) % PORTS;
    return c_pw'(s);
  endfunction

  function automatic logic [c_wiw-1:0] f_next(input logic [c_wiw-1:0] a, input logic [1:0] bte);
    logic [c_wiw-1:0] inc;
    logic [c_wiw-1:0] m;
    inc = a + c_one;
    case (bte)
      2'b01:   m = c_m4;
      2'b10:   m = c_m8;
      2'b11:   m = c_m16;
      default: m = '1;
    endcase
    return (a & ~m) | (inc & m);
  endfunction

  assign w_lock_live = r_lock & wb_cyc_i[r_lock_port];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic w_locked_here;
    assign w_cti[p]  = wb_cti_i[p*3 +: 3];
    assign w_bte[p]  = wb_bte_i[p*2 +: 2];
    assign w_widx[p] = wb_adr_i[p*AW + c_bsh +: c_wiw];
    assign w_burst[p] = (w_cti[p] == c_cti_const) || (w_cti[p] == c_cti_incr);
    assign w_locked_here = w_lock_live && (r_lock_port == c_pw'(p));
    // Burst beats stream one per cycle; classic/end beats wait out their own response.
    assign w_req[p] = wb_cyc_i[p] & wb_stb_i[p] &
                      (w_burst[p] | w_locked_here | ~(r_ack[p] | r_err[p]));
    assign wb_ack_o[p]            = r_ack[p];
    assign wb_err_o[p]            = r_err[p];
    assign wb_dat_o[p*DW +: DW]   = r_dat[p];

    if (c_bsh > 0) begin : g_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^wb_adr_i[p*AW +: c_bsh];
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_ptr;
    if (w_lock_live) begin
      w_gnt_vld = w_req[r_lock_port];
      w_gnt     = r_lock_port;
    end else begin
      // Scan downwards so the port closest to the pointer wins.
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (w_req[f_rr(r_ptr, i)]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = f_rr(r_ptr, i);
        end
      end
    end
  end

  assign w_cti_g   = w_cti[w_gnt];
  assign w_bte_g   = w_bte[w_gnt];
  assign w_we_g    = wb_we_i[w_gnt];
  assign w_sel_g   = wb_sel_i[w_gnt*c_bw +: c_bw];
  assign w_wdat_g  = wb_dat_i[w_gnt*DW +: DW];
  assign w_burst_g = (w_cti_g == c_cti_const) || (w_cti_g == c_cti_incr);
  assign w_addr    = w_lock_live ? r_cnt : w_widx[w_gnt];
  assign w_bad     = ({1'b0, w_addr} >= c_depth) || ((w_cti_g >= 3'd3) && (w_cti_g <= 3'd6));
  assign w_cnt_nxt = (w_cti_g == c_cti_const) ? w_addr : f_next(w_addr, w_bte_g);
  assign w_ptr_nxt = f_rr(w_gnt, 1);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack       <= '0;
      r_err       <= '0;
      r_lock      <= 1'b0;
      r_lock_port <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else begin
      r_ack  <= '0;
      r_err  <= '0;
      r_lock <= w_lock_live;
      if (w_gnt_vld) begin
        r_ack[w_gnt] <= ~w_bad;
        r_err[w_gnt] <= w_bad;
        r_ptr        <= w_ptr_nxt;
        r_lock       <= w_burst_g & ~w_bad;
        r_lock_port  <= w_gnt;
        r_cnt        <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && w_gnt_vld && !w_bad) begin
      for (int b = 0; b < c_bw; b++) begin
        if (w_we_g && w_sel_g[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdat_g[b*8 +: 8];
        end
      end
      r_dat[w_gnt] <= r_mem[w_addr];
    end
  end

endmodule

`default_nettype wire
